key_encoder16_4: RTL and testbench

KEY_ENCODER16_4 -- requirements
Module: key_encoder16_4

---
 rtl/key_encoder16_4.sv | 118 +++++++++++
 tb/tb_key_encoder16_4.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/key_encoder16_4.sv
// Debounced 16-to-4 priority encoder for piano key lines: synchronizes raw keys,
// debounces press and release of the top-priority key, and strobes each edge of valid.
module key_encoder16_4 #(
  parameter int unsigned DB_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] keys,
  input  logic        enable,
  output logic [3:0]  code,
  output logic        valid,
  output logic        press_pulse,
  output logic        release_pulse
);

  typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

  localparam logic [7:0] DB_LAST = 8'(DB_CYCLES);

  state_t      state;
  logic [15:0] keys_m;
  logic [15:0] keys_s;
  logic [7:0]  cnt;
  logic [3:0]  cand;
  logic        any;
  logic [3:0]  idx;
  logic        match_cand;
  logic        match_code;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      keys_m <= '0;
      keys_s <= '0;
    end else begin
      keys_m <= keys;
      keys_s <= keys_m;
    end
  end

  // Ascending scan so the highest set bit wins.
  always_comb begin
    idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (keys_s[i]) idx = 4'(i);
    end
    any        = |keys_s;
    match_cand = enable & any & (idx == cand);
    match_code = enable & any & (idx == code);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      cand          <= '0;
      code          <= '0;
      valid         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (enable && any) begin
            state <= PRESS_DB;
            cand  <= idx;
            cnt   <= 8'd1;
          end
        end
        PRESS_DB: begin
          if (match_cand) begin
            if (cnt == DB_LAST) begin
              state       <= HELD;
              code        <= cand;
              valid       <= 1'b1;
              press_pulse <= 1'b1;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end else begin
            state <= IDLE;
          end
        end
        HELD: begin
          if (match_code) begin
            state <= HELD;
          end else if (!enable) begin
            state         <= IDLE;
            valid         <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            state <= REL_DB;
            cnt   <= 8'd1;
          end
        end
        REL_DB: begin
          // Disabling bypasses the release debounce entirely.
          if (!enable) begin
            state         <= IDLE;
            valid         <= 1'b0;
            release_pulse <= 1'b1;
          end else if (match_code) begin
            state <= HELD;
          end else if (cnt == DB_LAST) begin
            state         <= IDLE;
            valid         <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_encoder16_4.sv
// Self-checking bench for key_encoder16_4: a cycle model of debounced key behaviour
// compared every cycle, plus directed scenarios with hand-computed expectations.
module tb_key_encoder16_4;

  localparam int DB = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] keys;
  logic        enable;
  logic [3:0]  code;
  logic        valid;
  logic        press_pulse;
  logic        release_pulse;

  int n_vectors = 0;
  int n_miscompares = 0;
  int n_press = 0;
  int n_release = 0;

  key_encoder16_4 #(.DB_CYCLES(DB)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .keys(keys),
    .enable(enable),
    .code(code),
    .valid(valid),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse)
  );

  always #5 clk = ~clk;

  // Model: two-sample delay on keys, then run lengths of consecutive qualifying samples.
  logic [15:0] m_s1, m_s;
  bit          m_held, m_press, m_release;
  int          m_run, m_rel, m_run_key;
  logic [3:0]  m_code;

  function automatic int top_key(logic [15:0] v);
    for (int i = 15; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    int k;
    if (!reset_n) begin
      m_s1 = '0; m_s = '0; m_held = 0; m_press = 0; m_release = 0;
      m_run = 0; m_rel = 0; m_run_key = 0; m_code = '0;
    end else begin
      k = top_key(m_s);
      m_press = 0;
      m_release = 0;
      if (!m_held) begin
        if (m_run == 0) begin
          if (enable && k >= 0) begin m_run = 1; m_run_key = k; end
        end else if (enable && k == m_run_key) begin
          if (m_run == DB) begin
            m_held = 1; m_code = 4'(m_run_key); m_press = 1; m_run = 0;
          end else m_run++;
        end else m_run = 0;
      end else begin
        if (!enable) begin
          m_held = 0; m_release = 1; m_rel = 0;
        end else if (k == int'(m_code)) m_rel = 0;
        else if (m_rel == 0) m_rel = 1;
        else if (m_rel == DB) begin
          m_held = 0; m_release = 1; m_rel = 0;
        end else m_rel++;
      end
      m_s = m_s1;
      m_s1 = keys;
    end
  end

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    n_vectors++;
    if (act !== exp) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("model_code", 16'(code), 16'(m_code));
    check("model_valid", 16'(valid), 16'(m_held));
    check("model_press", 16'(press_pulse), 16'(m_press));
    check("model_release", 16'(release_pulse), 16'(m_release));
    if (press_pulse) n_press++;
    if (release_pulse) n_release++;
  end

  task automatic step(int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int pc, rc;
    reset_n = 1'b0; enable = 1'b1; keys = '0;
    #1;
    check("rst_valid", 16'(valid), 16'h0);
    check("rst_code", 16'(code), 16'h0);
    check("rst_press", 16'(press_pulse), 16'h0);
    check("rst_release", 16'(release_pulse), 16'h0);
    step(2);
    reset_n = 1'b1;

    // Single key 5: valid after edge 7
    keys = 16'h0020; step(6);
    check("k5_not_yet", 16'(valid), 16'h0);
    step(1);
    check("k5_valid", 16'(valid), 16'h1);
    check("k5_code", 16'(code), 16'h5);
    check("k5_press", 16'(press_pulse), 16'h1);
    step(1);
    check("k5_press_once", 16'(press_pulse), 16'h0);

    // Debounced release
    keys = '0; step(6);
    check("rel_still_valid", 16'(valid), 16'h1);
    step(1);
    check("rel_valid", 16'(valid), 16'h0);
    check("rel_pulse", 16'(release_pulse), 16'h1);
    check("rel_code_kept", 16'(code), 16'h5);

    // Priority: keys 2 and 9
    step(5);
    keys = 16'h0204; step(7);
    check("prio_valid", 16'(valid), 16'h1);
    check("prio_code", 16'(code), 16'h9);
    keys = '0; step(10);

    // Bounce on key 3
    pc = n_press;
    keys = 16'h0008; step(2);
    keys = 16'h0000; step(1);
    keys = 16'h0008; step(6);
    check("bounce_not_yet", 16'(valid), 16'h0);
    step(1);
    check("bounce_valid", 16'(valid), 16'h1);
    check("bounce_code", 16'(code), 16'h3);
    check("bounce_press_count", 16'(n_press - pc), 16'h1);

    // Top key change 3 -> 5: full release then full press
    keys = 16'h0020; step(7);
    check("chg_rel_valid", 16'(valid), 16'h0);
    check("chg_rel_pulse", 16'(release_pulse), 16'h1);
    check("chg_rel_code", 16'(code), 16'h3);
    step(4);
    check("chg_code_hold", 16'(code), 16'h3);
    step(1);
    check("chg_valid", 16'(valid), 16'h1);
    check("chg_code", 16'(code), 16'h5);

    // Short release glitch rejected
    rc = n_release;
    keys = '0; step(2);
    keys = 16'h0020; step(10);
    check("glitch_valid", 16'(valid), 16'h1);
    check("glitch_no_release", 16'(n_release - rc), 16'h0);

    // Enable drop while held
    enable = 1'b0; step(1);
    check("en_valid", 16'(valid), 16'h0);
    check("en_release", 16'(release_pulse), 16'h1);
    check("en_code", 16'(code), 16'h5);
    step(5);
    check("en_idle", 16'(valid), 16'h0);
    enable = 1'b1; step(4);
    check("en_repress_wait", 16'(valid), 16'h0);
    step(1);
    check("en_repress", 16'(valid), 16'h1);

    // Enable drop during press debounce
    keys = '0; step(10);
    keys = 16'h0040; step(4);
    pc = n_press; rc = n_release;
    enable = 1'b0; step(1);
    check("pdb_no_valid", 16'(valid), 16'h0);
    enable = 1'b1; step(4);
    check("pdb_wait", 16'(valid), 16'h0);
    step(1);
    check("pdb_valid", 16'(valid), 16'h1);
    check("pdb_code", 16'(code), 16'h6);
    check("pdb_press_count", 16'(n_press - pc), 16'h1);
    check("pdb_no_release", 16'(n_release - rc), 16'h0);

    // Reset while held
    rc = n_release;
    #2 reset_n = 1'b0;
    #1;
    check("mrst_valid", 16'(valid), 16'h0);
    check("mrst_code", 16'(code), 16'h0);
    check("mrst_press", 16'(press_pulse), 16'h0);
    check("mrst_release", 16'(release_pulse), 16'h0);
    step(1);
    reset_n = 1'b1;
    step(6);
    check("mrst_wait", 16'(valid), 16'h0);
    step(1);
    check("mrst_valid_again", 16'(valid), 16'h1);
    check("mrst_code_again", 16'(code), 16'h6);
    check("mrst_no_release", 16'(n_release - rc), 16'h0);

    keys = '0; step(10);
    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
